// File: rtl/router_pkg.sv
// Shared constants for the router input virtual-channel block: flit geometry,
// VC indices and the per-VC request state encoding.
package router_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned HOP_LSB    = 48;
  localparam int unsigned HOP_W      = 8;

  localparam int unsigned EVEN = 0;
  localparam int unsigned ODD  = 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

endpackage

// File: rtl/vc_fifo.sv
// Show-ahead FIFO for one virtual channel; head_o is valid whenever empty_o is low.
// Pushes into a full FIFO and pops from an empty one are ignored.
module vc_fifo #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    pop_i,
  output logic [DATA_WIDTH-1:0]   head_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  occ_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic                  do_push, do_pop;

  always_comb begin
    full_o   = (cnt_q == (AW+1)'(DEPTH));
    empty_o  = (cnt_q == '0);
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    head_o   = mem_q[rd_ptr_q];
    occ_o    = cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/router_input_vc.sv
// Ring-router input port: one FIFO per virtual channel, phase-selected writes,
// hop-based routing of the in-phase head to the ring or the local PE.
module router_input_vc
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = router_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned NUM_VC     = 2,
  parameter int unsigned HOP_LSB    = router_pkg::HOP_LSB,
  parameter int unsigned HOP_W      = router_pkg::HOP_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               polarity,
  input  logic                               si,
  output logic                               ri,
  input  logic [DATA_WIDTH-1:0]              di,
  output logic [NUM_VC-1:0]                  req_fwd,
  output logic [NUM_VC-1:0]                  req_pe,
  input  logic [NUM_VC-1:0]                  gnt_fwd,
  input  logic [NUM_VC-1:0]                  gnt_pe,
  output logic [DATA_WIDTH-1:0]              data_out_fwd,
  output logic [DATA_WIDTH-1:0]              data_out_pe,
  output logic [NUM_VC*($clog2(DEPTH)+1)-1:0] occ,
  output logic [1:0]                         err
);

  localparam int unsigned OW = $clog2(DEPTH) + 1;

  logic [NUM_VC-1:0]     push, pop, full, empty, in_phase, hop_zero, dbl_gnt;
  logic [DATA_WIDTH-1:0] head [NUM_VC];
  logic [NUM_VC-1:0]     state_q, state_d;
  logic [1:0]            err_q, err_d;
  logic [DATA_WIDTH-1:0] fwd_q, pe_q;
  logic [DATA_WIDTH-1:0] cur_head, cur_fwd;
  logic [HOP_W-1:0]      cur_hop;
  logic                  cur_empty;
  int unsigned           wr_vc;

  for (genvar g = 0; g < NUM_VC; g++) begin : gen_vc
    vc_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (push[g]),
      .data_i  (di),
      .pop_i   (pop[g]),
      .head_o  (head[g]),
      .full_o  (full[g]),
      .empty_o (empty[g]),
      .occ_o   (occ[g*OW +: OW])
    );
  end

  always_comb begin
    wr_vc     = polarity ? ODD : EVEN;
    ri        = 1'b1;
    cur_empty = 1'b1;
    cur_head  = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      in_phase[v] = (v == wr_vc);
      if (in_phase[v]) begin
        ri        = ~full[v];
        cur_empty = empty[v];
        cur_head  = head[v];
      end
    end

    for (int unsigned v = 0; v < NUM_VC; v++) begin
      hop_zero[v] = (head[v][HOP_LSB +: HOP_W] == '0);
      req_pe[v]   = in_phase[v] & ~empty[v] & hop_zero[v];
      req_fwd[v]  = in_phase[v] & ~empty[v] & ~hop_zero[v];
      // At most one of the two grants can match, so a double grant pops once.
      pop[v]      = (gnt_fwd[v] & req_fwd[v]) | (gnt_pe[v] & req_pe[v]);
      dbl_gnt[v]  = gnt_fwd[v] & gnt_pe[v] & (req_fwd[v] | req_pe[v]);
      // ri ignores grants, so a full VC never accepts even while popping.
      push[v]     = in_phase[v] & si & ~full[v];

      state_d[v] = state_q[v];
      case (state_q[v])
        IDLE:    if (in_phase[v] && !empty[v] && !pop[v]) state_d[v] = REQ;
        REQ:     if (pop[v] || !in_phase[v]) state_d[v] = IDLE;
        default: state_d[v] = IDLE;
      endcase
    end

    cur_hop                      = cur_head[HOP_LSB +: HOP_W];
    cur_fwd                      = cur_head;
    cur_fwd[HOP_LSB +: HOP_W]    = cur_hop - HOP_W'(1);

    data_out_pe  = cur_empty ? pe_q : cur_head;
    data_out_fwd = cur_empty ? fwd_q : cur_fwd;

    err_d = err_q | {|dbl_gnt, si & ~ri};
    err   = err_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= '0;
      err_q   <= '0;
      fwd_q   <= '0;
      pe_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      fwd_q   <= data_out_fwd;
      pe_q    <= data_out_pe;
    end
  end

  // REQ is only ever held by a VC that still has the flit it is requesting for.
  always_ff @(posedge clk) begin
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (rst) begin
        assert (!(state_q[v] == REQ && empty[v]));
      end
    end
  end

endmodule

// File: tb/tb_router_input_vc.sv
// Directed bench for router_input_vc: fill/overflow, routing, hop decrement,
// push+pop with pointer wrap, double grant and asynchronous reset.
module tb_router_input_vc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        polarity = 1'b0;
  logic        si = 1'b0;
  logic        ri;
  logic [63:0] di = '0;
  logic [1:0]  req_fwd, req_pe;
  logic [1:0]  gnt_fwd = '0;
  logic [1:0]  gnt_pe = '0;
  logic [63:0] data_out_fwd, data_out_pe;
  logic [7:0]  occ;
  logic [1:0]  err;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] q0 [$];
  logic [63:0] exp_head;

  router_input_vc dut (
    .clk          (clk),
    .rst          (rst),
    .polarity     (polarity),
    .si           (si),
    .ri           (ri),
    .di           (di),
    .req_fwd      (req_fwd),
    .req_pe       (req_pe),
    .gnt_fwd      (gnt_fwd),
    .gnt_pe       (gnt_pe),
    .data_out_fwd (data_out_fwd),
    .data_out_pe  (data_out_pe),
    .occ          (occ),
    .err          (err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic [7:0] hop, input logic [15:0] tag);
    mk = {8'hA5, hop, 32'h1234_0000, tag};
  endfunction

  function automatic logic [63:0] fwdv(input logic [63:0] f);
    logic [63:0] r;
    r = f;
    r[55:48] = f[55:48] - 8'd1;
    return r;
  endfunction

  function automatic logic [63:0] vc1_flit(input int i);
    logic [7:0] hop;
    hop = (i == 0) ? 8'h00 : 8'(8'h06 + i);
    return mk(hop, 16'(16'h1000 + i));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Asynchronous reset, applied away from the clock edge.
    #2 rst = 1'b0;
    #1;
    chk("rst_ri", 64'(ri), 64'd1);
    chk("rst_occ", 64'(occ), 64'h00);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_req", 64'({req_fwd, req_pe}), 64'd0);
    chk("rst_dfwd", data_out_fwd, 64'd0);
    chk("rst_dpe", data_out_pe, 64'd0);
    tick();
    rst = 1'b1;

    // Fill VC1 with eight flits, no grants.
    polarity = 1'b1;
    for (int i = 0; i < 8; i++) begin
      si = 1'b1;
      di = vc1_flit(i);
      #1 chk($sformatf("fill_ri_%0d", i), 64'(ri), 64'd1);
      tick();
    end
    si = 1'b0;
    #1;
    chk("full_occ", 64'(occ), 64'h80);
    chk("full_ri_pol1", 64'(ri), 64'd0);

    // Overflow into full VC1.
    si = 1'b1;
    di = mk(8'h77, 16'hDEAD);
    tick();
    si = 1'b0;
    #1;
    chk("ovf_err", 64'(err), 64'd1);
    chk("ovf_occ", 64'(occ), 64'h80);

    // VC1 head has hop 0: PE route, exact data.
    chk("pe_req_pe", 64'(req_pe), 64'd2);
    chk("pe_req_fwd", 64'(req_fwd), 64'd0);
    chk("pe_data", data_out_pe, vc1_flit(0));

    // Switch to even phase: VC0 empty, outputs hold last values.
    polarity = 1'b0;
    #1;
    chk("pol0_ri", 64'(ri), 64'd1);
    chk("pol0_req", 64'({req_fwd, req_pe}), 64'd0);
    chk("hold_pe", data_out_pe, vc1_flit(0));
    chk("hold_fwd", data_out_fwd, mk(8'hFF, 16'h1000));

    // Load VC0 with four forward-bound flits.
    q0.push_back(mk(8'h03, 16'h000A));
    q0.push_back(mk(8'h04, 16'h000B));
    q0.push_back(mk(8'h05, 16'h000C));
    q0.push_back(mk(8'h06, 16'h000D));
    for (int i = 0; i < 4; i++) begin
      si = 1'b1;
      di = q0[i];
      tick();
    end
    si = 1'b0;
    #1;
    chk("vc0_occ4", 64'(occ), 64'h84);
    chk("fwd_req", 64'(req_fwd), 64'd1);
    chk("fwd_data", data_out_fwd, mk(8'h02, 16'h000A));
    gnt_fwd = 2'b01;
    tick();
    gnt_fwd = 2'b00;
    void'(q0.pop_front());
    #1;
    chk("fwd_pop_occ", 64'(occ), 64'h83);

    // Simultaneous push and pop on VC0 across pointer wrap.
    for (int k = 0; k < 20; k++) begin
      si = 1'b1;
      di = mk(8'(8'h10 + k), 16'(16'h2000 + k));
      gnt_fwd = 2'b01;
      exp_head = q0.pop_front();
      q0.push_back(di);
      #1 chk($sformatf("wrap_head_%0d", k), data_out_fwd, fwdv(exp_head));
      tick();
      chk($sformatf("wrap_occ_%0d", k), 64'(occ), 64'h83);
    end
    si = 1'b0;
    gnt_fwd = 2'b00;

    // Full VC1 pops but refuses the simultaneous push.
    polarity = 1'b1;
    si = 1'b1;
    di = mk(8'h55, 16'hBEEF);
    gnt_pe = 2'b10;
    #1;
    chk("fullpop_ri", 64'(ri), 64'd0);
    chk("fullpop_req_pe", 64'(req_pe), 64'd2);
    tick();
    si = 1'b0;
    gnt_pe = 2'b00;
    #1;
    chk("fullpop_occ", 64'(occ), 64'h73);
    chk("fullpop_head", data_out_pe, vc1_flit(1));
    chk("fullpop_req_fwd", 64'(req_fwd), 64'd2);

    // Double grant on VC1: single pop, sticky err[1].
    gnt_fwd = 2'b10;
    gnt_pe = 2'b10;
    tick();
    gnt_fwd = 2'b00;
    gnt_pe = 2'b00;
    #1;
    chk("dbl_occ", 64'(occ), 64'h63);
    chk("dbl_err", 64'(err), 64'd3);
    chk("dbl_head", data_out_fwd, fwdv(vc1_flit(2)));

    // Reset mid-stream takes effect without a clock edge.
    si = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_ri", 64'(ri), 64'd1);
    chk("mid_rst_occ", 64'(occ), 64'h00);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_req", 64'({req_fwd, req_pe}), 64'd0);
    chk("mid_rst_dfwd", data_out_fwd, 64'd0);
    chk("mid_rst_dpe", data_out_pe, 64'd0);
    si = 1'b0;
    tick();
    rst = 1'b1;

    // First push after release is accepted.
    polarity = 1'b0;
    si = 1'b1;
    di = mk(8'h09, 16'h00EE);
    tick();
    si = 1'b0;
    #1;
    chk("post_rst_occ", 64'(occ), 64'h01);
    chk("post_rst_req", 64'(req_fwd), 64'd1);
    chk("post_rst_data", data_out_fwd, mk(8'h08, 16'h00EE));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
